// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and a selectable show-ahead or registered read port.
module sync_fifo_pro #(
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 6,
  parameter int FIFO_ADDR_BIT = 3,
  parameter int AFULL_TH      = 5,
  parameter int AEMPTY_TH     = 1,
  parameter int OUT_REG       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_wr,
  input  logic                    fifo_rd,
  input  logic [FIFO_WIDTH-1:0]   fifo_din,
  output logic [FIFO_WIDTH-1:0]   fifo_do,
  output logic                    fifo_ful,
  output logic                    fifo_empty,
  output logic                    fifo_afull,
  output logic                    fifo_aempty,
  output logic [FIFO_ADDR_BIT:0]  fifo_cnt,
  output logic                    fifo_ovf,
  output logic                    fifo_udf
);

  localparam int CW = FIFO_ADDR_BIT + 1;
  localparam logic [FIFO_ADDR_BIT-1:0] PTR_LAST = FIFO_ADDR_BIT'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_TH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_TH);

  logic [FIFO_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [FIFO_ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     wr_acc, rd_acc;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_acc   = fifo_wr & (~fifo_ful | fifo_rd);
    rd_acc   = fifo_rd & ~fifo_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = fifo_wr & ~wr_acc;
    udf_d    = fifo_rd & ~rd_acc;
    // Pointers wrap explicitly so non-power-of-two depths work.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + 1'b1;
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= fifo_din;
  end

  if (OUT_REG != 0) begin : g_reg_out
    logic [FIFO_WIDTH-1:0] do_q;
    always_ff @(posedge clk) begin
      if (rst)         do_q <= '0;
      else if (rd_acc) do_q <= mem[rd_ptr_q];
    end
    assign fifo_do = do_q;
  end else begin : g_show_ahead
    assign fifo_do = mem[rd_ptr_q];
  end

  assign fifo_cnt    = cnt_q;
  assign fifo_ful    = (cnt_q == CNT_FULL);
  assign fifo_empty  = (cnt_q == '0);
  assign fifo_afull  = (cnt_q >= CNT_AF);
  assign fifo_aempty = (cnt_q <= CNT_AE);
  assign fifo_ovf    = ovf_q;
  assign fifo_udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Scoreboard bench: drives a show-ahead and a registered instance in lockstep and
// compares both against a queue-based model of the FIFO.
module tb_sync_fifo_pro;

  localparam int W  = 16;
  localparam int D  = 6;
  localparam int A  = 3;
  localparam int AF = 5;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_wr = 1'b0;
  logic         fifo_rd = 1'b0;
  logic [W-1:0] fifo_din = '0;

  logic [W-1:0] do0, do1;
  logic         ful0, empty0, afull0, aempty0, ovf0, udf0;
  logic         ful1, empty1, afull1, aempty1, ovf1, udf1;
  logic [A:0]   cnt0, cnt1;

  sync_fifo_pro #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_ADDR_BIT(A),
                  .AFULL_TH(AF), .AEMPTY_TH(AE), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .fifo_do(do0), .fifo_ful(ful0), .fifo_empty(empty0), .fifo_afull(afull0),
    .fifo_aempty(aempty0), .fifo_cnt(cnt0), .fifo_ovf(ovf0), .fifo_udf(udf0));

  sync_fifo_pro #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_ADDR_BIT(A),
                  .AFULL_TH(AF), .AEMPTY_TH(AE), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .fifo_do(do1), .fifo_ful(ful1), .fifo_empty(empty1), .fifo_afull(afull1),
    .fifo_aempty(aempty1), .fifo_cnt(cnt1), .fifo_ovf(ovf1), .fifo_udf(udf1));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    bit ful, empty, afull, aempty, ovf, udf, do1_zero;
  } state_t;

  state_t       exp_st_q[$];
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] model_q[$];

  int checks = 0;
  int failures = 0;
  int model_reads = 0;
  int dut0_reads = 0;
  int dut1_reads = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts reads and the post-edge state.
  task automatic cycle(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    state_t       s;
    bit           rd_ok, wr_ok;
    int           n;
    logic [W-1:0] v;
    @(negedge clk);
    rst = r; fifo_wr = w; fifo_rd = rd; fifo_din = d;
    s.do1_zero = 1'b0;
    if (r) begin
      model_q.delete();
      s.ovf = 1'b0;
      s.udf = 1'b0;
      s.do1_zero = 1'b1;
    end else begin
      n = model_q.size();
      rd_ok = rd && (n > 0);
      wr_ok = w && ((n < D) || rd);
      if (rd_ok) begin
        v = model_q.pop_front();
        exp0_q.push_back(v);
        exp1_q.push_back(v);
        model_reads++;
      end
      if (wr_ok) model_q.push_back(d);
      s.ovf = w && !wr_ok;
      s.udf = rd && !rd_ok;
    end
    n = model_q.size();
    s.cnt    = n;
    s.ful    = (n == D);
    s.empty  = (n == 0);
    s.afull  = (n >= AF);
    s.aempty = (n <= AE);
    exp_st_q.push_back(s);
  endtask

  // Monitor: sample pre-edge handshakes, compare just after the edge.
  initial begin
    bit           pres0, pend1;
    logic [W-1:0] d0;
    state_t       s;
    forever begin
      @(posedge clk);
      pres0 = !rst && fifo_rd && !empty0;
      pend1 = !rst && fifo_rd && !empty1;
      d0 = do0;
      #1;
      if (pres0) begin
        dut0_reads++;
        if (exp0_q.size() > 0) check("do_show_ahead", 32'(d0), 32'(exp0_q.pop_front()));
      end
      if (pend1) begin
        dut1_reads++;
        if (exp1_q.size() > 0) check("do_registered", 32'(do1), 32'(exp1_q.pop_front()));
      end
      if (exp_st_q.size() > 0) begin
        s = exp_st_q.pop_front();
        check("cnt0", 32'(cnt0), s.cnt);       check("cnt1", 32'(cnt1), s.cnt);
        check("ful0", 32'(ful0), 32'(s.ful));   check("ful1", 32'(ful1), 32'(s.ful));
        check("empty0", 32'(empty0), 32'(s.empty));   check("empty1", 32'(empty1), 32'(s.empty));
        check("afull0", 32'(afull0), 32'(s.afull));   check("afull1", 32'(afull1), 32'(s.afull));
        check("aempty0", 32'(aempty0), 32'(s.aempty)); check("aempty1", 32'(aempty1), 32'(s.aempty));
        check("ovf0", 32'(ovf0), 32'(s.ovf));   check("ovf1", 32'(ovf1), 32'(s.ovf));
        check("udf0", 32'(udf0), 32'(s.udf));   check("udf1", 32'(udf1), 32'(s.udf));
        if (s.do1_zero) check("do_registered_reset", 32'(do1), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle.
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    repeat (2) cycle(0, 0, 0, '0);

    // Fill 1..6, then an overflowing 7th write.
    for (int i = 1; i <= 6; i++) cycle(0, 1, 0, W'(i));
    cycle(0, 1, 0, 16'h0007);
    cycle(0, 0, 0, '0);

    // Drain six words, then an underflowing 7th read.
    repeat (6) cycle(0, 0, 1, '0);
    cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);

    // Wrap: 20 words streamed with occupancy held within 1..3.
    cycle(0, 1, 0, 16'h1000);
    cycle(0, 1, 0, 16'h1001);
    for (int k = 2; k < 20; k++) begin
      if (k % 2 == 0) begin
        cycle(0, 1, 0, W'(16'h1000 + k));
        cycle(0, 0, 1, '0);
      end else begin
        cycle(0, 1, 1, W'(16'h1000 + k));
      end
    end
    repeat (2) cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);

    // Full with simultaneous write and read: the new word comes out sixth.
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, W'($urandom));
    cycle(0, 1, 1, 16'hBEEF);
    repeat (6) cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);

    // Empty with simultaneous write and read: the read is dropped.
    cycle(0, 1, 1, 16'hCAFE);
    cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);

    // Reset mid-stream at count 4 with a write pending.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, W'($urandom));
    cycle(1, 1, 0, 16'hDEAD);
    cycle(0, 0, 1, '0);
    cycle(0, 1, 0, 16'h5A5A);
    cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);

    // Randomised traffic with write-heavy and read-heavy phases and rare resets.
    for (int i = 0; i < 400; i++) begin
      int unsigned wp;
      wp = ((i / 50) % 2 == 0) ? 3 : 1;
      cycle(($urandom_range(79) == 0), ($urandom_range(3) < wp),
            ($urandom_range(3) >= wp), W'($urandom));
    end
    repeat (3) cycle(0, 0, 0, '0);
    @(negedge clk);

    check("read_count_show_ahead", 32'(dut0_reads), 32'(model_reads));
    check("read_count_registered", 32'(dut1_reads), 32'(model_reads));
    check("pending_show_ahead", 32'(exp0_q.size()), 32'd0);
    check("pending_registered", 32'(exp1_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_pro.md
# sync_fifo_pro

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds an occupancy counter, programmable almost-full and almost-empty thresholds, overflow and underflow protection with error pulses, and a selectable show-ahead or registered read port. It sits between any same-clock producer and consumer in the datapath. It supports any depth from 2 to 2^FIFO_ADDR_BIT, including non-power-of-two depths.

## Interface
- FIFO_WIDTH, 16: data width in bits.
- FIFO_DEPTH, 6: number of entries, 2..2^FIFO_ADDR_BIT.
- FIFO_ADDR_BIT, 3: address bits; 2^FIFO_ADDR_BIT >= FIFO_DEPTH.
- AFULL_TH, 5: fifo_afull asserts when count >= AFULL_TH; legal range 1..FIFO_DEPTH.
- AEMPTY_TH, 1: fifo_aempty asserts when count <= AEMPTY_TH; legal range 0..FIFO_DEPTH-1.
- OUT_REG, 0: selects the read port mode.
  - 0: show-ahead; fifo_do is combinational from the head entry.
  - 1: registered; fifo_do updates on the clock edge that accepts a read.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- fifo_wr  in  1  write request.
- fifo_rd  in  1  read request.
- fifo_din  in  FIFO_WIDTH  write data.
- fifo_do  out  FIFO_WIDTH  read data.
- fifo_ful  out  1  full, count == FIFO_DEPTH.
- fifo_empty  out  1  empty, count == 0.
- fifo_afull  out  1  almost full.
- fifo_aempty  out  1  almost empty.
- fifo_cnt  out  FIFO_ADDR_BIT+1  current occupancy, 0..FIFO_DEPTH.
- fifo_ovf  out  1  one-cycle pulse: a write was dropped.
- fifo_udf  out  1  one-cycle pulse: a read was dropped.

## Operation
- Pointers:
  - wr_ptr and rd_ptr are FIFO_ADDR_BIT wide.
  - Each pointer wraps from FIFO_DEPTH-1 to 0. There is no wrap bit; occupancy comes from fifo_cnt.
- Accept rules, evaluated on the pre-edge state:
  - wr_acc = fifo_wr & (~fifo_ful | fifo_rd).
  - rd_acc = fifo_rd & ~fifo_empty.
- Write while full together with a read: both are accepted and the count is unchanged.
- Read while empty together with a write: the write is accepted and the read is dropped. There is no bypass, so the written word becomes readable on the next cycle.
- Count update, next fifo_cnt:
  - +1 if wr_acc & ~rd_acc.
  - -1 if rd_acc & ~wr_acc.
  - unchanged otherwise.
  - Never leaves 0..FIFO_DEPTH.
- Memory: mem[wr_ptr] <= fifo_din when wr_acc. The memory array is not reset.
- Read data, OUT_REG=0: fifo_do = mem[rd_ptr] combinationally. It is undefined while empty.
- Read data, OUT_REG=1: fifo_do <= mem[rd_ptr] when rd_acc; it holds otherwise.
- Flag derivation:
  - fifo_ful, fifo_empty, fifo_afull and fifo_aempty are decoded from the registered fifo_cnt only.
  - There is no combinational path from fifo_wr or fifo_rd to any flag.
- Error pulses:
  - fifo_ovf <= fifo_wr & ~wr_acc.
  - fifo_udf <= fifo_rd & ~rd_acc.
  - Each is high for exactly one cycle after the dropped request.
- Dropped requests leave pointers, count and memory unchanged.

## Timing
- Reset values (on a rst-high edge):
  - wr_ptr = rd_ptr = 0, fifo_cnt = 0.
  - fifo_empty = 1, fifo_aempty = 1, fifo_ful = 0, fifo_afull = 0.
  - fifo_ovf = fifo_udf = 0.
  - fifo_do = 0 when OUT_REG=1.
- rst has priority over fifo_wr and fifo_rd in the same cycle. Reset mid-operation discards all contents at once.
- Write-to-visible latency: 1 cycle. fifo_empty falls and fifo_cnt increments on the edge that accepts the write.
- Read latency:
  - OUT_REG=0: data is valid in the same cycle as fifo_rd, before the edge.
  - OUT_REG=1: data is valid the cycle after the accepting edge.
- Flags and fifo_cnt change only on clk edges.
- Wrap-around: a pointer at FIFO_DEPTH-1 goes to 0 on an accepted access, including for non-power-of-two FIFO_DEPTH.

## Test plan
- Reset then idle: fifo_cnt=0, fifo_empty=1, fifo_aempty=1, all other flags 0; with OUT_REG=1, fifo_do=0.
- Fill, DEPTH=6, AFULL_TH=5, AEMPTY_TH=1:
  - Write 0x0001..0x0006 on consecutive cycles.
  - fifo_aempty drops after the 2nd write.
  - fifo_afull rises after the 5th write.
  - fifo_ful rises after the 6th write; fifo_cnt=6.
  - A 7th write of 0x0007 gives fifo_ovf=1 for one cycle and leaves fifo_cnt=6.
- Drain in both modes:
  - Read 6 times and check fifo_do=0x0001..0x0006 in order; OUT_REG=1 lags by one cycle.
  - A 7th read gives fifo_udf=1 and leaves fifo_cnt=0.
- Wrap, DEPTH=6: stream 20 words with reads interleaved so that fifo_cnt stays in 1..3. Every word must come out in order with no drop and no error pulse.
- Simultaneous events:
  - When full, write plus read gives fifo_cnt=6, no fifo_ovf, and the new word is read sixth.
  - When empty, write plus read gives fifo_udf=1 and fifo_cnt=1.
- Reset mid-stream with fifo_cnt=4 and fifo_wr=1 asserted: the next cycle shows fifo_cnt=0 and fifo_empty=1. The dropped write leaves no data behind.
